ls1u_mem_arbiter: RTL and testbench
===================================

Name: ls1u_mem_arbiter

Overview:
- Shares one 8-bit single-port memory among three requesters: the LS1u+ core's 16-bit instruction fetch port, the core's 8-bit data port, and one external DMA master.
- Serialises each instruction fetch into two byte reads and holds the fetched word in a one-entry instruction buffer.
- Drives the core's WAIT (instruction stall) and WAIT_DATA (data stall) inputs.
- Sits between the core and the SoC memory/peripheral decode.

Parameters:
- AW, 24, address width of every port.
- HI_FIRST, 1, byte order of an instruction: 1 = even byte is instr[15:8]; 0 = even byte is instr[7:0].
- RR_EN, 1, fetch-vs-DMA policy: 1 = round-robin; 0 = fetch always beats DMA.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- cpu_iaddr  in  AW  instruction word address (core PC)
- cpu_instr  out  16  buffered instruction word
- cpu_iwait  out  1  to core WAIT; high = instruction not yet valid
- cpu_daddr  in  AW  data byte address
- cpu_dread  in  1  data read request
- cpu_dwrite  in  1  data write request
- cpu_dwdata  in  8  write data
- cpu_drdata  out  8  read data, valid in the completing cycle
- cpu_dwait  out  1  to core WAIT_DATA
- dma_req  in  1  DMA request; held with stable fields until dma_ack
- dma_we  in  1  DMA write
- dma_addr  in  AW  DMA byte address
- dma_wdata  in  8  DMA write data
- dma_rdata  out  8  DMA read data, valid while dma_ack=1
- dma_ack  out  1  one-cycle completion pulse
- mem_req  out  1  memory request
- mem_we  out  1  memory write
- mem_addr  out  AW  memory byte address
- mem_wdata  out  8  memory write data
- mem_rdata  in  8  memory read data
- mem_ready  in  1  completes the access in any cycle where mem_req=1

Behaviour:
- Memory protocol:
  - mem_req, mem_we, mem_addr and mem_wdata stay stable until the cycle with mem_req & mem_ready.
  - Read data is sampled in that cycle.
  - mem_ready may stay low indefinitely; no timeout.
- Instruction byte addresses:
  - even byte = {cpu_iaddr[AW-2:0],1'b0}; odd byte = even byte + 1.
  - Upper iaddr bit is dropped.
- Instruction buffer: registers ibuf_addr, ibuf_word, ibuf_valid.
  - cpu_iwait is combinational: !(ibuf_valid && ibuf_addr==cpu_iaddr).
  - cpu_instr = ibuf_word.
- Data-request gating:
  - A data request is dreq = (cpu_dread|cpu_dwrite) & !cpu_iwait.
  - Requests while cpu_iwait=1 are ignored, because the core decodes a stale instruction.
  - cpu_dwait = dreq & !(state==DATA & mem_ready).
  - cpu_drdata = mem_rdata, passed through in the completing cycle.
- FSM states: IDLE, IF_HI, IF_LO, DATA, DMA.
  - IDLE:
    - If dreq -> DATA.
    - Else if both DMA and fetch are needed: with RR_EN, grant whichever did not win last (last_grant flag); otherwise grant fetch.
    - Else if only cpu_iwait -> IF_HI (fetch); only dma_req -> DMA.
    - Otherwise stay.
    - In IDLE, mem_req=0. Every transaction costs one IDLE arbitration cycle.
  - IF_HI:
    - Read even byte; latch the target address at entry.
    - On mem_ready, store the byte -> IF_LO.
  - IF_LO:
    - Read odd byte.
    - On mem_ready, write ibuf_word, ibuf_addr = latched address, ibuf_valid=1 -> IDLE.
  - DATA:
    - mem_we=cpu_dwrite, mem_addr=cpu_daddr.
    - On mem_ready -> IDLE.
  - DMA:
    - Fields come from dma_* ports.
    - On mem_ready, dma_ack=1 and dma_rdata=mem_rdata -> IDLE.
- Minimum latencies with mem_ready tied high:
  - instruction: 3 cycles from a new cpu_iaddr to cpu_iwait=0;
  - data: 2 cycles (IDLE plus DATA).
- PC change during a fetch: the fetch completes using the latched address. The buffer then misses, and a new fetch follows.
- Coherency: a completed write (DATA or DMA) whose address equals either byte of ibuf_addr clears ibuf_valid in the same edge.
- dma_req dropped before ack: protocol violation, with undefined result. The bench asserts this never happens.
- Reset values:
  - state=IDLE, ibuf_valid=0, ibuf_word=16'h0000, ibuf_addr=0, last_grant=fetch;
  - mem_req=0, mem_we=0, dma_ack=0, dma_rdata=0;
  - consequently cpu_iwait=1 out of reset.
- Reset mid-transaction aborts immediately. mem_req drops asynchronously and no partial word is committed.

Decomposition:
- Shared package ls1u_pkg holds:
  - the state enum (IDLE/IF_HI/IF_LO/DATA/DMA);
  - grant encoding constants GNT_IF/GNT_DMA;
  - the default AW.
- One natural sub-module: ls1u_ibuf, holding the instruction buffer, hit compare, byte assembly and write-invalidate.

Test Plan:
- Reset release, mem_ready=1, cpu_iaddr=0x000010, memory 0x20=0xA5, 0x21=0x3C -> mem_addr 0x20 then 0x21; cpu_instr=0xA53C; cpu_iwait falls on cycle 3.
- Buffered instr valid, cpu_dread=1, cpu_daddr=0x001234 with memory 0x77, mem_ready low 2 cycles -> cpu_dwait high 3 cycles; cpu_drdata=0x77 when it drops.
- dma_req held and PC stepping each instruction, RR_EN=1 -> grants alternate fetch, DMA, fetch; dma_ack exactly one cycle per transfer.
- DMA write 0x55 to 0x000021 while ibuf_addr=0x10 valid -> ibuf_valid cleared, cpu_iwait=1, refetch returns 0xA555.
- cpu_dread=1 while cpu_iwait=1 -> no DATA grant, mem_addr shows only fetch addresses.
- rst pulsed during IF_LO -> mem_req=0 immediately, ibuf_valid=0; after release, fetch restarts at the even byte.

Source files
------------

// File: rtl/ls1u_pkg.sv
// Shared definitions for the LS1u+ memory arbiter: FSM encoding, grant
// encoding and the default address width.
package ls1u_pkg;

   localparam int LS1U_AW = 24;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_IF_HI = 3'd1,
      ST_IF_LO = 3'd2,
      ST_DATA  = 3'd3,
      ST_DMA   = 3'd4
   } state_t;

   // Remembers who won the last fetch-vs-DMA decision.
   localparam logic GNT_IF  = 1'b0;
   localparam logic GNT_DMA = 1'b1;

endpackage

// File: rtl/ls1u_ibuf.sv
// One-entry instruction buffer: assembles two fetched bytes into a word,
// reports hit/miss against the core PC, and drops itself on a write to its bytes.
module ls1u_ibuf
   import ls1u_pkg::*;
#(
   parameter int AW       = LS1U_AW,
   parameter bit HI_FIRST = 1'b1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [AW-1:0] iaddr,
   input  logic [AW-1:0] fill_addr,
   input  logic [7:0]    fill_byte,
   input  logic          fill_first,
   input  logic          fill_last,
   input  logic          wr_done,
   input  logic [AW-1:0] wr_addr,
   output logic [15:0]   instr,
   output logic          iwait
);

   logic [AW-1:0] ibuf_addr;
   logic [15:0]   ibuf_word;
   logic          ibuf_valid;
   logic [7:0]    even_byte;
   logic [15:0]   word_nx;
   logic          wr_hit;

   // Even byte arrives first; HI_FIRST decides which half it lands in.
   assign word_nx = HI_FIRST ? {even_byte, fill_byte} : {fill_byte, even_byte};
   assign wr_hit  = wr_done && (wr_addr[AW-1:1] == ibuf_addr[AW-2:0]);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ibuf_addr  <= '0;
         ibuf_word  <= 16'h0000;
         ibuf_valid <= 1'b0;
         even_byte  <= 8'h00;
      end else begin
         if (fill_first)
            even_byte <= fill_byte;
         if (fill_last) begin
            ibuf_word  <= word_nx;
            ibuf_addr  <= fill_addr;
            ibuf_valid <= 1'b1;
         end else if (wr_hit) begin
            ibuf_valid <= 1'b0;
         end
      end
   end

   assign instr = ibuf_word;
   assign iwait = !(ibuf_valid && (ibuf_addr == iaddr));

endmodule

// File: rtl/ls1u_mem_arbiter.sv
// Shares one 8-bit memory port between the LS1u+ instruction fetch (two byte
// reads per word), the core data port and a DMA master.
module ls1u_mem_arbiter
   import ls1u_pkg::*;
#(
   parameter int AW       = LS1U_AW,
   parameter bit HI_FIRST = 1'b1,
   parameter bit RR_EN    = 1'b1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [AW-1:0] cpu_iaddr,
   output logic [15:0]   cpu_instr,
   output logic          cpu_iwait,
   input  logic [AW-1:0] cpu_daddr,
   input  logic          cpu_dread,
   input  logic          cpu_dwrite,
   input  logic [7:0]    cpu_dwdata,
   output logic [7:0]    cpu_drdata,
   output logic          cpu_dwait,
   input  logic          dma_req,
   input  logic          dma_we,
   input  logic [AW-1:0] dma_addr,
   input  logic [7:0]    dma_wdata,
   output logic [7:0]    dma_rdata,
   output logic          dma_ack,
   output logic          mem_req,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [7:0]    mem_wdata,
   input  logic [7:0]    mem_rdata,
   input  logic          mem_ready
);

   state_t        state, state_nx;
   logic          last_grant;
   logic [AW-1:0] fetch_addr;
   logic          dreq;
   logic          grant_if, grant_dma;

   // Data requests made against a stale instruction are not real requests.
   assign dreq = (cpu_dread | cpu_dwrite) & ~cpu_iwait;

   always_comb begin
      grant_if  = 1'b0;
      grant_dma = 1'b0;
      if (state == ST_IDLE && !dreq) begin
         if (cpu_iwait && dma_req) begin
            if (RR_EN && last_grant == GNT_IF)
               grant_dma = 1'b1;
            else
               grant_if = 1'b1;
         end else if (cpu_iwait) begin
            grant_if = 1'b1;
         end else if (dma_req) begin
            grant_dma = 1'b1;
         end
      end
   end

   always_comb begin
      state_nx = state;
      case (state)
         ST_IDLE: begin
            if (dreq)           state_nx = ST_DATA;
            else if (grant_if)  state_nx = ST_IF_HI;
            else if (grant_dma) state_nx = ST_DMA;
         end
         ST_IF_HI: if (mem_ready) state_nx = ST_IF_LO;
         ST_IF_LO: if (mem_ready) state_nx = ST_IDLE;
         ST_DATA:  if (mem_ready) state_nx = ST_IDLE;
         ST_DMA:   if (mem_ready) state_nx = ST_IDLE;
         default:                 state_nx = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= ST_IDLE;
         last_grant <= GNT_IF;
         fetch_addr <= '0;
      end else begin
         state <= state_nx;
         if (grant_if) begin
            last_grant <= GNT_IF;
            fetch_addr <= cpu_iaddr;
         end else if (grant_dma) begin
            last_grant <= GNT_DMA;
         end
      end
   end

   // Memory fields decode straight from state so reset kills mem_req at once.
   always_comb begin
      mem_req   = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = 8'h00;
      case (state)
         ST_IF_HI: begin
            mem_req  = 1'b1;
            mem_addr = {fetch_addr[AW-2:0], 1'b0};
         end
         ST_IF_LO: begin
            mem_req  = 1'b1;
            mem_addr = {fetch_addr[AW-2:0], 1'b1};
         end
         ST_DATA: begin
            mem_req   = 1'b1;
            mem_we    = cpu_dwrite;
            mem_addr  = cpu_daddr;
            mem_wdata = cpu_dwdata;
         end
         ST_DMA: begin
            mem_req   = 1'b1;
            mem_we    = dma_we;
            mem_addr  = dma_addr;
            mem_wdata = dma_wdata;
         end
         default: ;
      endcase
   end

   assign cpu_dwait  = dreq & ~(state == ST_DATA && mem_ready);
   assign cpu_drdata = mem_rdata;
   assign dma_ack    = (state == ST_DMA) && mem_ready;
   assign dma_rdata  = dma_ack ? mem_rdata : 8'h00;

   ls1u_ibuf #(.AW(AW), .HI_FIRST(HI_FIRST)) u_ibuf (
      .clk        (clk),
      .rst        (rst),
      .iaddr      (cpu_iaddr),
      .fill_addr  (fetch_addr),
      .fill_byte  (mem_rdata),
      .fill_first (state == ST_IF_HI && mem_ready),
      .fill_last  (state == ST_IF_LO && mem_ready),
      .wr_done    (mem_req && mem_ready && mem_we),
      .wr_addr    (mem_addr),
      .instr      (cpu_instr),
      .iwait      (cpu_iwait)
   );

endmodule

// File: tb/tb_ls1u_mem_arbiter.sv
// Directed bench for ls1u_mem_arbiter: expected memory accesses, data reads and
// DMA completions are queued by the stimulus and checked by a negedge monitor.
module tb_ls1u_mem_arbiter;

   localparam int AW = 24;

   typedef struct packed {
      logic          we;
      logic [AW-1:0] addr;
      logic [7:0]    wd;
   } mexp_t;

   logic          clk = 1'b0;
   logic          rst;
   logic [AW-1:0] cpu_iaddr;
   logic [15:0]   cpu_instr;
   logic          cpu_iwait;
   logic [AW-1:0] cpu_daddr;
   logic          cpu_dread, cpu_dwrite;
   logic [7:0]    cpu_dwdata, cpu_drdata;
   logic          cpu_dwait;
   logic          dma_req, dma_we;
   logic [AW-1:0] dma_addr;
   logic [7:0]    dma_wdata, dma_rdata;
   logic          dma_ack;
   logic          mem_req, mem_we;
   logic [AW-1:0] mem_addr;
   logic [7:0]    mem_wdata, mem_rdata;
   logic          mem_ready;

   logic          tb_init;
   logic [7:0]    mem [0:4095];
   mexp_t         exp_mem [$];
   logic [8:0]    exp_dma [$];
   logic [7:0]    exp_drd [$];
   mexp_t         mon_e;
   logic [8:0]    mon_d;
   logic [7:0]    mon_r;
   int            n_vec = 0;
   int            n_bad = 0;

   always #5 clk = ~clk;

   ls1u_mem_arbiter #(.AW(AW), .HI_FIRST(1'b1), .RR_EN(1'b1)) dut (
      .clk(clk), .rst(rst),
      .cpu_iaddr(cpu_iaddr), .cpu_instr(cpu_instr), .cpu_iwait(cpu_iwait),
      .cpu_daddr(cpu_daddr), .cpu_dread(cpu_dread), .cpu_dwrite(cpu_dwrite),
      .cpu_dwdata(cpu_dwdata), .cpu_drdata(cpu_drdata), .cpu_dwait(cpu_dwait),
      .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr),
      .dma_wdata(dma_wdata), .dma_rdata(dma_rdata), .dma_ack(dma_ack),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
   );

   function automatic logic [7:0] init_byte(input int a);
      case (a)
         'h020: return 8'hA5;
         'h021: return 8'h3C;
         'h022: return 8'h11;
         'h023: return 8'h22;
         'h024: return 8'h33;
         'h025: return 8'h44;
         'h030: return 8'h5A;
         'h031: return 8'h6B;
         'h032: return 8'h7C;
         'h234: return 8'h77;
         default: return 8'h00;
      endcase
   endfunction

   always @(posedge clk) begin
      if (tb_init) begin
         for (int i = 0; i < 4096; i++) mem[i] <= init_byte(i);
      end else if (mem_req && mem_ready && mem_we) begin
         mem[mem_addr[11:0]] <= mem_wdata;
      end
   end
   assign mem_rdata = mem[mem_addr[11:0]];

   a_dma_hold: assert property (@(posedge clk) disable iff (rst)
      (dma_req && !dma_ack) |=> dma_req)
      else $error("dma_req dropped before dma_ack");

   always @(negedge clk) begin
      if (!rst && !tb_init) begin
         if (mem_req && mem_ready) begin
            n_vec++;
            if (exp_mem.size() == 0) begin
               n_bad++;
               $display("FAIL mem_access: got we=%b addr=%h wd=%h, expected no access", mem_we, mem_addr, mem_wdata);
            end else begin
               mon_e = exp_mem.pop_front();
               if (mem_we !== mon_e.we || mem_addr !== mon_e.addr || (mon_e.we && mem_wdata !== mon_e.wd)) begin
                  n_bad++;
                  $display("FAIL mem_access: got we=%b addr=%h wd=%h, expected we=%b addr=%h wd=%h",
                           mem_we, mem_addr, mem_wdata, mon_e.we, mon_e.addr, mon_e.wd);
               end
            end
         end
         if (dma_ack) begin
            n_vec++;
            if (exp_dma.size() == 0) begin
               n_bad++;
               $display("FAIL dma_ack: got ack with rdata=%h, expected none", dma_rdata);
            end else begin
               mon_d = exp_dma.pop_front();
               if (mon_d[8] && dma_rdata !== mon_d[7:0]) begin
                  n_bad++;
                  $display("FAIL dma_rdata: got %h expected %h", dma_rdata, mon_d[7:0]);
               end
            end
         end
         if (cpu_dread && !cpu_iwait && !cpu_dwait) begin
            n_vec++;
            if (exp_drd.size() == 0) begin
               n_bad++;
               $display("FAIL cpu_drdata: got completion %h, expected none", cpu_drdata);
            end else begin
               mon_r = exp_drd.pop_front();
               if (cpu_drdata !== mon_r) begin
                  n_bad++;
                  $display("FAIL cpu_drdata: got %h expected %h", cpu_drdata, mon_r);
               end
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
      n_vec++;
      if (act !== expv) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", nm, act, expv);
      end
   endtask

   task automatic push_rd(input logic [AW-1:0] a);
      mexp_t e;
      e.we = 1'b0; e.addr = a; e.wd = 8'h00;
      exp_mem.push_back(e);
   endtask

   task automatic wait_iwait_low(input string nm);
      for (int c = 0; c < 60; c++) begin
         @(negedge clk);
         if (!cpu_iwait) return;
      end
      n_vec++; n_bad++;
      $display("FAIL %s: cpu_iwait still 1 after 60 cycles, expected 0", nm);
   endtask

   task automatic wait_ack(input string nm);
      for (int c = 0; c < 60; c++) begin
         @(negedge clk);
         if (dma_ack) return;
      end
      n_vec++; n_bad++;
      $display("FAIL %s: no dma_ack after 60 cycles, expected 1", nm);
   endtask

   initial begin
      mexp_t w;
      rst = 1'b1; tb_init = 1'b1; mem_ready = 1'b0;
      cpu_iaddr = '0; cpu_daddr = '0; cpu_dread = 1'b0; cpu_dwrite = 1'b0; cpu_dwdata = 8'h00;
      dma_req = 1'b0; dma_we = 1'b0; dma_addr = '0; dma_wdata = 8'h00;
      repeat (3) tick();
      tb_init = 1'b0;

      chk("rst_iwait", 32'(cpu_iwait), 32'h1);
      chk("rst_mem_req", 32'(mem_req), 32'h0);
      chk("rst_dma_ack", 32'(dma_ack), 32'h0);
      chk("rst_instr", 32'(cpu_instr), 32'h0);

      // Cold fetch of word 0x10 -> bytes 0x20, 0x21.
      cpu_iaddr = 24'h000010; mem_ready = 1'b1;
      push_rd(24'h20); push_rd(24'h21);
      rst = 1'b0;
      tick(); chk("fetch_c1_iwait", 32'(cpu_iwait), 32'h1);
      tick(); chk("fetch_c2_iwait", 32'(cpu_iwait), 32'h1);
      tick(); chk("fetch_c3_iwait", 32'(cpu_iwait), 32'h0);
      chk("fetch_instr", 32'(cpu_instr), 32'hA53C);

      // Data read with two wait-states from memory.
      cpu_daddr = 24'h001234; cpu_dread = 1'b1; mem_ready = 1'b0;
      push_rd(24'h001234); exp_drd.push_back(8'h77);
      #1 chk("dwait_c1", 32'(cpu_dwait), 32'h1);
      tick(); chk("dwait_c2", 32'(cpu_dwait), 32'h1);
      tick(); chk("dwait_c3", 32'(cpu_dwait), 32'h1);
      mem_ready = 1'b1;
      #1 chk("dwait_done", 32'(cpu_dwait), 32'h0);
      tick(); cpu_dread = 1'b0;

      // Held DMA vs stepping PC: DMA, fetch, DMA, fetch, DMA.
      push_rd(24'h30); push_rd(24'h22); push_rd(24'h23);
      push_rd(24'h31); push_rd(24'h24); push_rd(24'h25); push_rd(24'h32);
      exp_dma.push_back({1'b1, 8'h5A}); exp_dma.push_back({1'b1, 8'h6B}); exp_dma.push_back({1'b1, 8'h7C});
      fork
         begin
            cpu_iaddr = 24'h000011; wait_iwait_low("rr_pc11"); tick();
            cpu_iaddr = 24'h000012; wait_iwait_low("rr_pc12");
         end
         begin
            for (int k = 0; k < 3; k++) begin
               dma_we = 1'b0; dma_addr = 24'h30 + 24'(k); dma_req = 1'b1;
               wait_ack("rr_dma"); tick();
            end
            dma_req = 1'b0;
         end
      join
      chk("rr_instr", 32'(cpu_instr), 32'h3344);

      // DMA write into a buffered byte invalidates and forces a refetch.
      cpu_iaddr = 24'h000010; push_rd(24'h20); push_rd(24'h21);
      wait_iwait_low("coh_fill"); tick();
      chk("coh_pre_instr", 32'(cpu_instr), 32'hA53C);
      w.we = 1'b1; w.addr = 24'h21; w.wd = 8'h55;
      exp_mem.push_back(w); exp_dma.push_back({1'b0, 8'h00});
      dma_we = 1'b1; dma_addr = 24'h000021; dma_wdata = 8'h55; dma_req = 1'b1;
      wait_ack("coh_dma"); tick();
      dma_req = 1'b0; dma_we = 1'b0;
      chk("coh_iwait", 32'(cpu_iwait), 32'h1);
      push_rd(24'h20); push_rd(24'h21);
      wait_iwait_low("coh_refetch"); tick();
      chk("coh_instr", 32'(cpu_instr), 32'hA555);

      // Data read while the instruction is stale must wait for the fetch.
      cpu_iaddr = 24'h000011; cpu_daddr = 24'h001234; cpu_dread = 1'b1;
      push_rd(24'h22); push_rd(24'h23); push_rd(24'h001234); exp_drd.push_back(8'h77);
      #1 chk("gate_dwait", 32'(cpu_dwait), 32'h0);
      begin : wait_data
         for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if (cpu_dread && !cpu_iwait && !cpu_dwait) disable wait_data;
         end
         n_vec++; n_bad++;
         $display("FAIL gate_data: no data completion after 60 cycles, expected one");
      end
      tick(); cpu_dread = 1'b0;
      chk("gate_instr", 32'(cpu_instr), 32'h1122);

      // Reset while in IF_LO aborts the fetch; it restarts at the even byte.
      cpu_iaddr = 24'h000012; push_rd(24'h24);
      tick(); tick();
      mem_ready = 1'b0;
      #2 rst = 1'b1;
      #1 chk("rst_mid_mem_req", 32'(mem_req), 32'h0);
      chk("rst_mid_iwait", 32'(cpu_iwait), 32'h1);
      tick(); tick();
      rst = 1'b0; mem_ready = 1'b1;
      push_rd(24'h24); push_rd(24'h25);
      wait_iwait_low("rst_refetch"); tick();
      chk("rst_instr", 32'(cpu_instr), 32'h3344);

      repeat (3) tick();
      while (exp_mem.size() != 0) begin
         mon_e = exp_mem.pop_front(); n_vec++; n_bad++;
         $display("FAIL mem_missing: got nothing, expected access addr=%h we=%b", mon_e.addr, mon_e.we);
      end
      while (exp_dma.size() != 0) begin
         mon_d = exp_dma.pop_front(); n_vec++; n_bad++;
         $display("FAIL dma_missing: got nothing, expected ack rdata=%h", mon_d[7:0]);
      end
      while (exp_drd.size() != 0) begin
         mon_r = exp_drd.pop_front(); n_vec++; n_bad++;
         $display("FAIL drd_missing: got nothing, expected read data %h", mon_r);
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
